adc_loop_sequencer: RTL and testbench

Sample-rate sequencer for the closed control loop. It times each sample period, drives the serial ADC frame (cs, sclk, 16-bit shift-in), and hands the 12-bit result to the PI-D stage with a one-cycle enable. It then captures the controller output and loads it into the PWM duty register only at a PWM period boundary. It sits between the serial ADC pins, the I_PD controller and the PWM generator, replacing their free-running enables with one scheduled pipeline.

---
 rtl/adc_loop_sequencer_if.sv | 31 +++
 rtl/adc_loop_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_adc_loop_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_loop_sequencer_if.sv
// adc_loop_sequencer_if
// Bundles the signals the sequencer exchanges with the serial ADC, the PI-D
// controller and the PWM generator.
//   ADC side   : cs, sclk (to ADC), sdata (from ADC)
//   controller : adc_data, zeros, adc_valid, pid_en (to controller), pid_in (from controller)
//   PWM side   : duty_out, duty_load (to PWM), pwm_sync (from PWM)
// The master modport is the sequencer; the slave modport is the
// ADC/controller/PWM environment around it.
interface adc_loop_sequencer_if;
  logic        cs;
  logic        sclk;
  logic        sdata;
  logic [11:0] adc_data;
  logic [3:0]  zeros;
  logic        adc_valid;
  logic        pid_en;
  logic [7:0]  pid_in;
  logic        pwm_sync;
  logic [7:0]  duty_out;
  logic        duty_load;

  modport master (
    output cs, sclk, adc_data, zeros, adc_valid, pid_en, duty_out, duty_load,
    input  sdata, pid_in, pwm_sync
  );

  modport slave (
    input  cs, sclk, adc_data, zeros, adc_valid, pid_en, duty_out, duty_load,
    output sdata, pid_in, pwm_sync
  );
endinterface

// File: rtl/adc_loop_sequencer.sv
// adc_loop_sequencer
// Times each sample period, runs one 16-bit serial ADC frame, hands the
// 12-bit result to the controller with a one-cycle enable, captures the
// controller output and loads it into the PWM duty register at the next
// PWM period boundary.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   EN         sample-timer enable
//   clr        synchronous clear of the sticky flags
//   bus        adc_loop_sequencer_if.master (ADC pins, controller, PWM)
//   busy       high whenever the sequencer is not idle
//   overrun    sticky: a sample tick arrived while busy
//   frame_err  sticky: a frame had nonzero leading bits
module adc_loop_sequencer #(
  parameter int SAMPLE_DIV  = 5000,
  parameter int SCLK_DIV    = 4,
  parameter int CALC_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  EN,
  input  logic                  clr,
  adc_loop_sequencer_if.master  bus,
  output logic                  busy,
  output logic                  overrun,
  output logic                  frame_err
);

  localparam int CNT_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int HALF_W = $clog2(SCLK_DIV + 1);
  localparam int CALC_W = $clog2(CALC_CYCLES + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(SCLK_DIV - 1);
  localparam logic [CALC_W-1:0] CALC_LAST = CALC_W'(CALC_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    LATCH,
    CALC,
    UPDATE
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]  sample_cnt;
  logic              tick;
  logic [HALF_W-1:0] half_cnt;
  logic [4:0]        half_idx;
  logic [15:0]       shift;
  logic [CALC_W-1:0] calc_cnt;
  logic [7:0]        pid_cap;
  logic [11:0]       adc_data_q;
  logic [3:0]        zeros_q;
  logic [7:0]        duty_q;
  logic              duty_load_q;

  logic half_end;
  logic sample_bit;
  logic conv_done;
  logic calc_done;
  logic sync_hit;

  // Each sclk bit is two halves of SCLK_DIV cycles: even half_idx is the
  // low half, odd is the high half. The bit is sampled on the edge that
  // ends a low half, i.e. the edge that drives sclk high.
  assign tick       = EN && (sample_cnt == CNT_LAST);
  assign half_end   = (half_cnt == HALF_LAST);
  assign sample_bit = (state == CONV) && half_end && !half_idx[0];
  assign conv_done  = (state == CONV) && half_end && (half_idx == 5'd31);
  assign calc_done  = (state == CALC) && (calc_cnt == CALC_LAST);
  assign sync_hit   = (state == UPDATE) && bus.pwm_sync;

  // Free-running sample timer; parked at zero while EN is low so the first
  // tick after enabling comes a full sample period later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_cnt <= '0;
    end else if (!EN || tick) begin
      sample_cnt <= '0;
    end else begin
      sample_cnt <= sample_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A tick outside IDLE is dropped here and only recorded as overrun.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tick)      state_next = CONV;
      CONV:    if (conv_done) state_next = LATCH;
      LATCH:                  state_next = CALC;
      CALC:    if (calc_done) state_next = UPDATE;
      UPDATE:  if (bus.pwm_sync) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Serial frame timing and shift register. The counters are held at zero
  // outside CONV so every frame starts from a clean low half.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      half_cnt <= '0;
      half_idx <= '0;
      shift    <= '0;
    end else begin
      if (state != CONV) begin
        half_cnt <= '0;
        half_idx <= '0;
      end else if (half_end) begin
        half_cnt <= '0;
        half_idx <= half_idx + 5'd1;
      end else begin
        half_cnt <= half_cnt + HALF_W'(1);
      end
      if (sample_bit) begin
        shift <= {shift[14:0], bus.sdata};
      end
    end
  end

  // Result registers load on the edge entering LATCH so the data is
  // already stable during the adc_valid cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adc_data_q <= '0;
      zeros_q    <= '0;
    end else if (conv_done) begin
      adc_data_q <= shift[11:0];
      zeros_q    <= shift[15:12];
    end
  end

  // Controller window: pid_in is captured in the last CALC cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      calc_cnt <= '0;
      pid_cap  <= '0;
    end else begin
      if (state == CALC) begin
        calc_cnt <= calc_cnt + CALC_W'(1);
      end else begin
        calc_cnt <= '0;
      end
      if (calc_done) begin
        pid_cap <= bus.pid_in;
      end
    end
  end

  // Signed controller output becomes offset-binary duty by flipping the
  // sign bit; it is applied only on a PWM period boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      duty_q      <= 8'd128;
      duty_load_q <= 1'b0;
    end else begin
      duty_load_q <= sync_hit;
      if (sync_hit) begin
        duty_q <= {~pid_cap[7], pid_cap[6:0]};
      end
    end
  end

  // Sticky flags: a set condition in the same cycle as clr wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (tick && (state != IDLE)) begin
        overrun <= 1'b1;
      end else if (clr) begin
        overrun <= 1'b0;
      end
      if (conv_done && (shift[15:12] != 4'd0)) begin
        frame_err <= 1'b1;
      end else if (clr) begin
        frame_err <= 1'b0;
      end
    end
  end

  assign busy          = (state != IDLE);
  assign bus.cs        = (state != CONV);
  assign bus.sclk      = (state == CONV) ? half_idx[0] : 1'b1;
  assign bus.adc_valid = (state == LATCH);
  assign bus.pid_en    = (state == CALC) && (calc_cnt == '0);
  assign bus.adc_data  = adc_data_q;
  assign bus.zeros     = zeros_q;
  assign bus.duty_out  = duty_q;
  assign bus.duty_load = duty_load_q;

endmodule

// File: tb/tb_adc_loop_sequencer.sv
// tb_adc_loop_sequencer
// Self-checking bench for adc_loop_sequencer with SAMPLE_DIV=100,
// SCLK_DIV=2, CALC_CYCLES=4. A timeline model (frame offsets from the
// accepted tick) predicts every output each cycle; directed scenarios add
// literal checks for the frame contents, duty conversion, flags and reset.
module tb_adc_loop_sequencer;

  localparam int SD   = 100;
  localparam int D    = 2;
  localparam int CC   = 4;
  localparam int CONV = 32 * D;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic [7:0] pid_in = 8'd0;
  logic pwm_sync = 1'b0;
  logic sdata_drv = 1'b0;
  logic busy, overrun, frame_err;

  bit adc_mode = 1'b1;
  logic [15:0] adc_word = 16'h0000;

  int tests_run = 0;
  int tests_failed = 0;

  adc_loop_sequencer_if bus ();

  assign bus.sdata    = sdata_drv;
  assign bus.pid_in   = pid_in;
  assign bus.pwm_sync = pwm_sync;

  adc_loop_sequencer #(
    .SAMPLE_DIV (SD),
    .SCLK_DIV   (D),
    .CALC_CYCLES(CC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .EN       (en),
    .clr      (clr),
    .bus      (bus),
    .busy     (busy),
    .overrun  (overrun),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ADC behaviour: presents the next MSB-first bit after each sclk fall
  // inside a frame, either from adc_word or random.
  int adc_idx = 0;
  logic prev_sclk = 1'b1;
  always @(posedge clk) begin
    #1;
    if (bus.cs) begin
      adc_idx = 0;
    end else if (!bus.sclk && prev_sclk) begin
      if (adc_mode && adc_idx < 16) sdata_drv = adc_word[15 - adc_idx];
      else sdata_drv = 1'($urandom);
      adc_idx++;
    end
    prev_sclk = bus.sclk;
  end

  // Timeline model: a frame is anchored at the cycle T of its accepted
  // tick; everything else is a fixed offset from T, except the end, which
  // waits for the first pwm_sync once the captured value is ready.
  int m_cyc, m_cnt, m_T;
  bit m_busy, m_wait, m_ovr, m_ferr;
  logic [15:0] m_word;
  logic [7:0] m_cap, m_duty;
  logic [11:0] m_adc;
  logic [3:0] m_zr;
  bit e_cs, e_sclk, e_valid, e_pid, e_load;

  always @(posedge clk or negedge rst) begin
    int off, offn;
    bit busy_b, tick, ovr_set, ferr_set;
    if (!rst) begin
      m_cyc = 0; m_cnt = 0; m_T = 0; m_busy = 0; m_wait = 0;
      m_ovr = 0; m_ferr = 0; m_word = '0; m_cap = '0; m_duty = 8'd128;
      m_adc = '0; m_zr = '0;
      e_cs = 1; e_sclk = 1; e_valid = 0; e_pid = 0; e_load = 0;
    end else begin
      busy_b = m_busy;
      tick = en && (m_cnt == SD - 1);
      m_cnt = (!en || tick) ? 0 : m_cnt + 1;
      ovr_set = 0; ferr_set = 0; e_load = 0;
      if (busy_b) begin
        off = m_cyc - m_T;
        if (off >= 1 && off <= CONV && ((off - 1) % (2 * D)) == D - 1)
          m_word[15 - (off - 1) / (2 * D)] = bus.sdata;
        if (off == CONV) begin
          m_adc = m_word[11:0];
          m_zr = m_word[15:12];
          ferr_set = (m_word[15:12] != 4'd0);
        end
        if (m_wait && pwm_sync) begin
          m_duty = m_cap + 8'd128;
          e_load = 1;
          m_busy = 0;
          m_wait = 0;
        end else if (off == CONV + 1 + CC) begin
          m_cap = pid_in;
          m_wait = 1;
        end
      end
      if (tick) begin
        if (busy_b) ovr_set = 1;
        else begin m_busy = 1; m_T = m_cyc; m_word = '0; end
      end
      if (ovr_set) m_ovr = 1; else if (clr) m_ovr = 0;
      if (ferr_set) m_ferr = 1; else if (clr) m_ferr = 0;
      m_cyc++;
      offn = m_cyc - m_T;
      e_cs = !(m_busy && offn >= 1 && offn <= CONV);
      e_sclk = e_cs ? 1'b1 : ((((offn - 1) / D) % 2) == 1);
      e_valid = m_busy && offn == CONV + 1;
      e_pid = m_busy && offn == CONV + 2;
    end
  end

  always @(posedge clk) begin
    #1;
    check_output("cs", 16'(bus.cs), 16'(e_cs));
    check_output("sclk", 16'(bus.sclk), 16'(e_sclk));
    check_output("busy", 16'(busy), 16'(m_busy));
    check_output("adc_valid", 16'(bus.adc_valid), 16'(e_valid));
    check_output("pid_en", 16'(bus.pid_en), 16'(e_pid));
    check_output("duty_load", 16'(bus.duty_load), 16'(e_load));
    check_output("duty_out", 16'(bus.duty_out), 16'(m_duty));
    check_output("adc_data", 16'(bus.adc_data), 16'(m_adc));
    check_output("zeros", 16'(bus.zeros), 16'(m_zr));
    check_output("overrun", 16'(overrun), 16'(m_ovr));
    check_output("frame_err", 16'(frame_err), 16'(m_ferr));
  end

  // Waits at negedges for a DUT event: 0 cs low, 1 adc_valid, 2 pid_en,
  // 3 duty_load, 4 not busy.
  task automatic wait_event(input string name, input int which, input int budget);
    bit hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      case (which)
        0: hit = !bus.cs;
        1: hit = bus.adc_valid;
        2: hit = bus.pid_en;
        3: hit = bus.duty_load;
        default: hit = !busy;
      endcase
    end
    check_output({name, "_seen"}, 16'(hit), 16'd1);
  endtask

  task automatic finish_frame();
    pwm_sync = 1'b1;
    wait_event("duty_load", 3, 400);
    pwm_sync = 1'b0;
  endtask

  task automatic measure_start(input string name);
    int n = 0;
    bit hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clk);
      #1;
      n++;
      hit = !bus.cs;
    end
    check_output(name, 16'(n), 16'(SD));
  endtask

  task automatic apply_stimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      pid_in = 8'($urandom);
      pwm_sync = ($urandom_range(0, 7) == 0);
      clr = ($urandom_range(0, 63) == 0);
      if (i % 50 == 0) en = ($urandom_range(0, 9) != 0);
    end
    @(negedge clk);
    clr = 1'b0;
    pwm_sync = 1'b0;
  endtask

  initial begin
    int cs_low, rises;
    bit prev;
    bit hit;
    en = 1'b1;
    adc_mode = 1'b1;
    adc_word = 16'h0A5C;
    pid_in = 8'hF0;
    repeat (3) @(negedge clk);
    check_output("rst_cs", 16'(bus.cs), 16'd1);
    check_output("rst_sclk", 16'(bus.sclk), 16'd1);
    check_output("rst_duty", 16'(bus.duty_out), 16'd128);
    check_output("rst_busy", 16'(busy), 16'd0);
    rst = 1'b1;

    // First frame: tick at count SD-1, 64 low cycles with 16 sclk rises.
    measure_start("first_tick");
    cs_low = 1; rises = 0; prev = bus.sclk; hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clk);
      #1;
      hit = bus.adc_valid;
      if (!hit) begin
        if (!bus.cs) cs_low++;
        if (!bus.cs && bus.sclk && !prev) rises++;
        prev = bus.sclk;
      end
    end
    check_output("cs_low_cycles", 16'(cs_low), 16'd64);
    check_output("sclk_rises", 16'(rises), 16'd16);
    check_output("adc_data_lit", 16'(bus.adc_data), 16'h0A5C);
    check_output("zeros_lit", 16'(bus.zeros), 16'd0);
    check_output("frame_err_lit", 16'(frame_err), 16'd0);
    @(posedge clk);
    #1;
    check_output("valid_pulse", 16'(bus.adc_valid), 16'd0);

    // Duty update waits for pwm_sync; 0xF0 becomes 0x70.
    wait_event("pid_en", 2, 50);
    repeat (20) @(negedge clk);
    check_output("duty_hold", 16'(bus.duty_out), 16'd128);
    pwm_sync = 1'b1;
    @(negedge clk);
    pwm_sync = 1'b0;
    check_output("duty_load_lit", 16'(bus.duty_load), 16'd1);
    check_output("duty_lit", 16'(bus.duty_out), 16'h70);

    // Nonzero leading bits: sticky frame_err until clr.
    adc_word = 16'h3FFF;
    wait_event("cs2", 0, 150);
    wait_event("valid2", 1, 100);
    check_output("zeros_3", 16'(bus.zeros), 16'h3);
    check_output("ferr_set", 16'(frame_err), 16'd1);
    finish_frame();
    adc_word = 16'h0123;
    repeat (5) @(negedge clk);
    check_output("ferr_sticky", 16'(frame_err), 16'd1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check_output("ferr_clr", 16'(frame_err), 16'd0);
    check_output("ovr_none", 16'(overrun), 16'd0);

    // Withheld pwm_sync: the next tick is dropped as an overrun.
    wait_event("cs3", 0, 150);
    cs_low = 1;
    repeat (150) begin
      @(negedge clk);
      if (!bus.cs) cs_low++;
    end
    check_output("single_frame", 16'(cs_low), 16'd64);
    check_output("ovr_set", 16'(overrun), 16'd1);
    finish_frame();
    wait_event("cs_after_ovr", 0, 110);
    finish_frame();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check_output("ovr_clr", 16'(overrun), 16'd0);

    // EN dropped mid-frame: frame finishes, no further ticks.
    adc_word = 16'h0ABC;
    wait_event("cs_en", 0, 150);
    repeat (10) @(negedge clk);
    en = 1'b0;
    finish_frame();
    cs_low = 0;
    repeat (300) begin
      @(negedge clk);
      if (!bus.cs) cs_low++;
    end
    check_output("en_off_quiet", 16'(cs_low), 16'd0);

    // Randomized traffic, random ADC bits.
    adc_mode = 1'b0;
    en = 1'b1;
    apply_stimulus(3000);

    // Reset in the middle of bit 8 of a frame.
    adc_mode = 1'b1;
    en = 1'b1;
    pwm_sync = 1'b1;
    wait_event("idle", 4, 300);
    pwm_sync = 1'b0;
    wait_event("cs_rst", 0, 250);
    repeat (32) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_output("arst_cs", 16'(bus.cs), 16'd1);
    check_output("arst_sclk", 16'(bus.sclk), 16'd1);
    check_output("arst_busy", 16'(busy), 16'd0);
    check_output("arst_duty", 16'(bus.duty_out), 16'd128);
    @(negedge clk);
    rst = 1'b1;
    measure_start("tick_after_rst");
    finish_frame();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
